// File: rtl/router_pkg.sv
// Shared definitions for the router output-port slice: header field layout,
// framing states, the forwarded beat format and the default stall timeout.
package router_pkg;

    localparam int HDR_LEN_MSB    = 7;
    localparam int HDR_LEN_LSB    = 2;
    localparam int HDR_DEST_MSB   = 1;
    localparam int ROUTER_TIMEOUT = 30;

    typedef enum logic [1:0] {
        HDR,
        BODY,
        FLUSH
    } frame_state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } beat_t;

    // Words still expected after a header: L payload bytes plus the parity byte.
    function automatic logic [6:0] hdr_words_left(input logic [7:0] hdr);
        return {1'b0, hdr[HDR_LEN_MSB:HDR_LEN_LSB]} + 7'd1;
    endfunction

endpackage

// File: rtl/router_out_skid.sv
// Two-entry {data, sop, eop} output buffer; entry 0 is the head presented to
// the client. Flush empties it synchronously and takes priority over push/pop.
module router_out_skid
    import router_pkg::*;
(
    input  logic       clk_in,
    input  logic       resetn,
    input  logic       push,
    input  beat_t      push_beat,
    input  logic       pop,
    input  logic       flush,
    output beat_t      head,
    output logic [1:0] occ
);

    beat_t      entry_reg [2];
    logic [1:0] occ_reg;

    always_ff @(posedge clk_in) begin
        if (!resetn || flush) begin
            entry_reg[0] <= '0;
            entry_reg[1] <= '0;
            occ_reg      <= 2'd0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (occ_reg == 2'd2) begin
                        entry_reg[0] <= entry_reg[1];
                        entry_reg[1] <= push_beat;
                    end else begin
                        entry_reg[0] <= push_beat;
                    end
                end
                2'b01: begin
                    entry_reg[0] <= entry_reg[1];
                    occ_reg      <= occ_reg - 2'd1;
                end
                2'b10: begin
                    if (occ_reg == 2'd0) begin
                        entry_reg[0] <= push_beat;
                    end else begin
                        entry_reg[1] <= push_beat;
                    end
                    occ_reg <= occ_reg + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign head = entry_reg[0];
    assign occ  = occ_reg;

endmodule

// File: rtl/router_out_port.sv
// Read-side controller for one router output FIFO: frames packets, forwards them
// on a valid/ready stream and times out stalled clients. ROUTER_OUT_PARITY_CHK_EN builds the parity checker.
module router_out_port
    import router_pkg::*;
#(
    parameter int TIMEOUT = ROUTER_TIMEOUT
) (
    input  logic       clk_in,
    input  logic       resetn,
    input  logic       fifo_empty_in,
    output logic       fifo_rd_en_out,
    input  logic [7:0] fifo_data_in,
    input  logic       fifo_hdr_in,
    output logic [7:0] m_data_out,
    output logic       m_valid_out,
    input  logic       m_ready_in,
    output logic       m_sop_out,
    output logic       m_eop_out,
    output logic       parity_err_out,
    output logic       frame_err_out,
    output logic       soft_reset_out
);

    frame_state_t state_reg, state_next;
    logic [6:0]   rem_reg, rem_next;
    logic [7:0]   stall_cnt_reg, stall_cnt_next;
    logic         inflight_reg;

    logic         push, pop, stall, timeout, rd_en, frame_err;
    beat_t        push_beat, head;
    logic [1:0]   occ;
    logic [2:0]   pending;

    router_out_skid u_skid (
        .clk_in    (clk_in),
        .resetn    (resetn),
        .push      (push),
        .push_beat (push_beat),
        .pop       (pop),
        .flush     (timeout),
        .head      (head),
        .occ       (occ)
    );

    assign m_valid_out = (occ != 2'd0);
    assign m_data_out  = head.data;
    assign m_sop_out   = head.sop;
    assign m_eop_out   = head.eop;

    assign pop     = m_valid_out && m_ready_in;
    assign stall   = m_valid_out && !m_ready_in;
    assign timeout = stall && (stall_cnt_reg == 8'(TIMEOUT - 1));
    assign stall_cnt_next = (stall && !timeout) ? stall_cnt_reg + 8'd1 : 8'd0;

    // A read is allowed only if the buffer can still absorb it when it lands next cycle.
    assign pending = {1'b0, occ} + {2'b00, inflight_reg};
    assign rd_en   = resetn && !fifo_empty_in && (state_reg != FLUSH) &&
                     ((pending < 3'd2) || ((pending == 3'd2) && pop));

    always_comb begin
        state_next     = state_reg;
        rem_next       = rem_reg;
        push           = 1'b0;
        push_beat      = '0;
        frame_err      = 1'b0;
        case (state_reg)
            FLUSH: state_next = HDR;
            default: begin
                if (inflight_reg) begin
                    if (fifo_hdr_in) begin
                        frame_err      = (state_reg == BODY);
                        rem_next       = hdr_words_left(fifo_data_in);
                        push           = 1'b1;
                        push_beat.data = fifo_data_in;
                        push_beat.sop  = 1'b1;
                        state_next     = BODY;
                    end else if (state_reg == BODY) begin
                        rem_next       = rem_reg - 7'd1;
                        push           = 1'b1;
                        push_beat.data = fifo_data_in;
                        push_beat.eop  = (rem_reg == 7'd1);
                        if (rem_reg == 7'd1) begin
                            state_next = HDR;
                        end
                    end else begin
                        frame_err = 1'b1;
                    end
                end
            end
        endcase
        if (timeout) begin
            state_next = FLUSH;
            rem_next   = '0;
            push       = 1'b0;
            push_beat  = '0;
            frame_err  = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!resetn) begin
            state_reg     <= HDR;
            rem_reg       <= '0;
            stall_cnt_reg <= '0;
            inflight_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rem_reg       <= rem_next;
            stall_cnt_reg <= stall_cnt_next;
            inflight_reg  <= rd_en;
        end
    end

    assign fifo_rd_en_out = rd_en;
    assign frame_err_out  = resetn && frame_err;
    assign soft_reset_out = resetn && timeout;

`ifdef ROUTER_OUT_PARITY_CHK_EN
    logic [7:0] par_reg, par_next;
    logic       parity_err;

    // The running XOR excludes the parity byte itself, so it must equal that byte.
    always_comb begin
        par_next   = par_reg;
        parity_err = 1'b0;
        if (timeout) begin
            par_next = '0;
        end else if (push && push_beat.sop) begin
            par_next = fifo_data_in;
        end else if (push) begin
            par_next   = par_reg ^ fifo_data_in;
            parity_err = push_beat.eop && (par_reg != fifo_data_in);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!resetn) begin
            par_reg <= '0;
        end else begin
            par_reg <= par_next;
        end
    end

    assign parity_err_out = resetn && parity_err;
`else
    assign parity_err_out = 1'b0;
`endif

endmodule
